// File: rtl/issue_queue_pkg.sv
// Shared types for the issue stage: the decoded element handed over by decode
// and the per-slot record held inside the issue queue.
package issue_queue_pkg;

  localparam int XLEN     = 32;
  localparam int REG_W    = 5;
  localparam int IQ_DEPTH = 8;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_ADDU,
    OP_SUBU,
    OP_AND,
    OP_OR,
    OP_ORI,
    OP_XOR,
    OP_SLT,
    OP_LUI,
    OP_BEQ,
    OP_BNE,
    OP_J
  } iq_op_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  predict_pc_addr;
    logic             predict_brunch_taken;
    iq_op_e           op;
    logic             num1_need;
    logic [REG_W-1:0] num1_addr;
    logic [XLEN-1:0]  num1;
    logic             num2_need;
    logic [REG_W-1:0] num2_addr;
    logic [XLEN-1:0]  num2;
    logic             write_reg_en;
    logic [REG_W-1:0] write_reg_addr;
  } ISSUE_QUEUE_ELEMENT;

  typedef struct packed {
    ISSUE_QUEUE_ELEMENT elem;
    logic               valid;
    logic               num1_ready;
    logic               num2_ready;
  } IQ_ENTRY;

endpackage

// File: rtl/issue_queue_operand_capture.sv
// Resolves one source operand: keeps an already captured value, otherwise takes
// it from the register file, then from the writeback broadcast.
module iq_operand_capture
  import issue_queue_pkg::*;
(
  input  logic             need_i,
  input  logic [REG_W-1:0] addr_i,
  input  logic             cur_ready_i,
  input  logic [XLEN-1:0]  cur_val_i,
  input  logic             rf_ready_i,
  input  logic [XLEN-1:0]  rf_data_i,
  input  logic             wb_valid_i,
  input  logic [REG_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             ready_o,
  output logic [XLEN-1:0]  val_o
);

  always_comb begin
    ready_o = cur_ready_i;
    val_o   = cur_val_i;
    if (!cur_ready_i) begin
      if (!need_i) begin
        // Unused source: the slot carries the immediate untouched.
        ready_o = 1'b1;
      end else if (addr_i == '0) begin
        ready_o = 1'b1;
        val_o   = '0;
      end else if (rf_ready_i) begin
        ready_o = 1'b1;
        val_o   = rf_data_i;
      end else if (wb_valid_i && (wb_addr_i == addr_i)) begin
        // addr_i is non-zero here, so r0 broadcasts never wake anything.
        ready_o = 1'b1;
        val_o   = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// In-order issue buffer between decode and execute: captures operands at
// enqueue or from writeback, and presents the oldest entry once it is complete.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               enq_valid,
  output logic               enq_ready,
  input  ISSUE_QUEUE_ELEMENT enq_elem,
  input  logic               rf_num1_ready,
  input  logic [XLEN-1:0]    rf_num1_data,
  input  logic               rf_num2_ready,
  input  logic [XLEN-1:0]    rf_num2_data,
  input  logic               wb_valid,
  input  logic [REG_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  output logic               iss_valid,
  input  logic               iss_ready,
  output ISSUE_QUEUE_ELEMENT iss_elem,
  output logic [PTR_W:0]     count
);

  IQ_ENTRY          entries_q [DEPTH];
  IQ_ENTRY          entries_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  IQ_ENTRY          head_entry;
  IQ_ENTRY          enq_entry;
  logic             full;
  logic             enq_fire;
  logic             iss_fire;

  logic             enq_num1_ready, enq_num2_ready;
  logic [XLEN-1:0]  enq_num1_val, enq_num2_val;

  assign full       = (count_q == (PTR_W+1)'(DEPTH));
  assign head_entry = entries_q[head_q];

  assign enq_ready  = !full;
  assign iss_valid  = head_entry.valid && head_entry.num1_ready && head_entry.num2_ready;
  assign iss_elem   = head_entry.elem;
  assign count      = count_q;

  assign enq_fire   = enq_valid && enq_ready;
  assign iss_fire   = iss_valid && iss_ready;

  iq_operand_capture u_enq_num1 (
    .need_i      (enq_elem.num1_need),
    .addr_i      (enq_elem.num1_addr),
    .cur_ready_i (1'b0),
    .cur_val_i   (enq_elem.num1),
    .rf_ready_i  (rf_num1_ready),
    .rf_data_i   (rf_num1_data),
    .wb_valid_i  (wb_valid),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .ready_o     (enq_num1_ready),
    .val_o       (enq_num1_val)
  );

  iq_operand_capture u_enq_num2 (
    .need_i      (enq_elem.num2_need),
    .addr_i      (enq_elem.num2_addr),
    .cur_ready_i (1'b0),
    .cur_val_i   (enq_elem.num2),
    .rf_ready_i  (rf_num2_ready),
    .rf_data_i   (rf_num2_data),
    .wb_valid_i  (wb_valid),
    .wb_addr_i   (wb_addr),
    .wb_data_i   (wb_data),
    .ready_o     (enq_num2_ready),
    .val_o       (enq_num2_val)
  );

  always_comb begin
    enq_entry            = '0;
    enq_entry.elem       = enq_elem;
    enq_entry.elem.num1  = enq_num1_val;
    enq_entry.elem.num2  = enq_num2_val;
    enq_entry.valid      = 1'b1;
    enq_entry.num1_ready = enq_num1_ready;
    enq_entry.num2_ready = enq_num2_ready;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic            wake1_ready, wake2_ready;
    logic [XLEN-1:0] wake1_val, wake2_val;
    IQ_ENTRY         entry_d;

    // Wakeup path: the register file is never consulted after enqueue.
    iq_operand_capture u_wake1 (
      .need_i      (entries_q[gi].elem.num1_need),
      .addr_i      (entries_q[gi].elem.num1_addr),
      .cur_ready_i (entries_q[gi].num1_ready),
      .cur_val_i   (entries_q[gi].elem.num1),
      .rf_ready_i  (1'b0),
      .rf_data_i   ('0),
      .wb_valid_i  (wb_valid),
      .wb_addr_i   (wb_addr),
      .wb_data_i   (wb_data),
      .ready_o     (wake1_ready),
      .val_o       (wake1_val)
    );

    iq_operand_capture u_wake2 (
      .need_i      (entries_q[gi].elem.num2_need),
      .addr_i      (entries_q[gi].elem.num2_addr),
      .cur_ready_i (entries_q[gi].num2_ready),
      .cur_val_i   (entries_q[gi].elem.num2),
      .rf_ready_i  (1'b0),
      .rf_data_i   ('0),
      .wb_valid_i  (wb_valid),
      .wb_addr_i   (wb_addr),
      .wb_data_i   (wb_data),
      .ready_o     (wake2_ready),
      .val_o       (wake2_val)
    );

    always_comb begin
      entry_d = entries_q[gi];
      if (entries_q[gi].valid) begin
        entry_d.num1_ready = wake1_ready;
        entry_d.elem.num1  = wake1_val;
        entry_d.num2_ready = wake2_ready;
        entry_d.elem.num2  = wake2_val;
      end
      if (iss_fire && (head_q == PTR_W'(gi))) begin
        entry_d.valid = 1'b0;
      end
      // Enqueue and issue never target the same slot: that needs empty or full.
      if (enq_fire && (tail_q == PTR_W'(gi))) begin
        entry_d = enq_entry;
      end
      if (flush) begin
        entry_d.valid      = 1'b0;
        entry_d.num1_ready = 1'b0;
        entry_d.num2_ready = 1'b0;
      end
    end

    assign entries_d[gi] = entry_d;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + PTR_W'(1);
      if (iss_fire) head_d = head_q + PTR_W'(1);
      case ({enq_fire, iss_fire})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  a_no_enq_when_full: assert property (@(posedge clk) disable iff (rst)
    !(enq_fire && full));

  a_no_iss_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(iss_fire && (count_q == '0)));

  // Pointer distance matches count modulo DEPTH; count alone tells full from empty.
  a_occupancy: assert property (@(posedge clk) disable iff (rst)
    ((tail_q - head_q) == count_q[PTR_W-1:0]) && (count_q <= (PTR_W+1)'(DEPTH)));

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: stimulus pushes expected issued elements into
// a scoreboard queue, and a negedge monitor pops and compares each issue.
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic               clk;
  logic               rst;
  logic               flush;
  logic               enq_valid;
  logic               enq_ready;
  ISSUE_QUEUE_ELEMENT enq_elem;
  logic               rf_num1_ready;
  logic [31:0]        rf_num1_data;
  logic               rf_num2_ready;
  logic [31:0]        rf_num2_data;
  logic               wb_valid;
  logic [4:0]         wb_addr;
  logic [31:0]        wb_data;
  logic               iss_valid;
  logic               iss_ready;
  ISSUE_QUEUE_ELEMENT iss_elem;
  logic [3:0]         count;

  int n_checks = 0;
  int n_errors = 0;
  ISSUE_QUEUE_ELEMENT exp_q[$];

  issue_queue #(.DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .enq_valid     (enq_valid),
    .enq_ready     (enq_ready),
    .enq_elem      (enq_elem),
    .rf_num1_ready (rf_num1_ready),
    .rf_num1_data  (rf_num1_data),
    .rf_num2_ready (rf_num2_ready),
    .rf_num2_data  (rf_num2_data),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .iss_valid     (iss_valid),
    .iss_ready     (iss_ready),
    .iss_elem      (iss_elem),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (actual=running required=finished)");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ISSUE_QUEUE_ELEMENT mk(input logic [31:0] pc, input iq_op_e op,
                                            input logic n1_need, input logic [4:0] n1_addr,
                                            input logic [31:0] n1, input logic n2_need,
                                            input logic [4:0] n2_addr, input logic [31:0] n2);
    ISSUE_QUEUE_ELEMENT e;
    e = '0;
    e.pc                   = pc;
    e.predict_pc_addr      = pc + 32'd8;
    e.predict_brunch_taken = pc[2];
    e.op                   = op;
    e.num1_need            = n1_need;
    e.num1_addr            = n1_addr;
    e.num1                 = n1;
    e.num2_need            = n2_need;
    e.num2_addr            = n2_addr;
    e.num2                 = n2;
    e.write_reg_en         = 1'b1;
    e.write_reg_addr       = pc[6:2];
    return e;
  endfunction

  task automatic push_exp(input ISSUE_QUEUE_ELEMENT e, input logic [31:0] n1, input logic [31:0] n2);
    ISSUE_QUEUE_ELEMENT x;
    x      = e;
    x.num1 = n1;
    x.num2 = n2;
    exp_q.push_back(x);
  endtask

  // Monitor: one line per issued element, compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL issue_unexpected: actual pc=0x%0h required=no issue", iss_elem.pc);
      end else begin
        ISSUE_QUEUE_ELEMENT x;
        x = exp_q.pop_front();
        if (iss_elem !== x) begin
          n_errors++;
          $display("FAIL issue_elem: actual pc=0x%0h num1=0x%0h num2=0x%0h required pc=0x%0h num1=0x%0h num2=0x%0h",
                   iss_elem.pc, iss_elem.num1, iss_elem.num2, x.pc, x.num1, x.num2);
        end else begin
          $display("issue pc=0x%0h num1=0x%0h num2=0x%0h", iss_elem.pc, iss_elem.num1, iss_elem.num2);
        end
      end
    end
  end

  initial begin
    ISSUE_QUEUE_ELEMENT e;
    rst = 1'b1; flush = 1'b0; enq_valid = 1'b0; enq_elem = '0;
    rf_num1_ready = 1'b0; rf_num1_data = '0; rf_num2_ready = 1'b0; rf_num2_data = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; iss_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("reset_count", 32'(count), 0);
    chk("reset_enq_ready", 32'(enq_ready), 1);
    chk("reset_iss_valid", 32'(iss_valid), 0);

    // ORI: num1 from register file, num2 is the immediate.
    iss_ready = 1'b1;
    e = mk(32'h100, OP_ORI, 1'b1, 5'd1, 32'h0, 1'b0, 5'd0, 32'h1234);
    enq_valid = 1'b1; enq_elem = e; rf_num1_ready = 1'b1; rf_num1_data = 32'h10;
    push_exp(e, 32'h10, 32'h1234);
    tick();
    enq_valid = 1'b0; rf_num1_ready = 1'b0;
    chk("ori_iss_valid", 32'(iss_valid), 1);
    chk("ori_count", 32'(count), 1);
    tick();
    chk("ori_count_after", 32'(count), 0);
    chk("ori_iss_valid_after", 32'(iss_valid), 0);

    // ADDU: r2 pending, woken by a broadcast two cycles later.
    e = mk(32'h104, OP_ADDU, 1'b1, 5'd1, 32'h0, 1'b1, 5'd2, 32'h0);
    enq_valid = 1'b1; enq_elem = e; rf_num1_ready = 1'b1; rf_num1_data = 32'h7;
    push_exp(e, 32'h7, 32'h55);
    tick();
    enq_valid = 1'b0; rf_num1_ready = 1'b0;
    chk("addu_wait1", 32'(iss_valid), 0);
    tick();
    chk("addu_wait2", 32'(iss_valid), 0);
    wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 32'h55;
    chk("addu_wait_bcast_cycle", 32'(iss_valid), 0);
    tick();
    wb_valid = 1'b0;
    chk("addu_woken", 32'(iss_valid), 1);
    tick();
    chk("addu_count_after", 32'(count), 0);

    // Same-cycle bypass on num1; num2 reads r0 and must be zero.
    e = mk(32'h108, OP_ADDU, 1'b1, 5'd5, 32'h0, 1'b1, 5'd0, 32'hdead);
    enq_valid = 1'b1; enq_elem = e;
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'haa;
    push_exp(e, 32'haa, 32'h0);
    chk("bypass_same_cycle", 32'(iss_valid), 0);
    tick();
    enq_valid = 1'b0; wb_valid = 1'b0;
    chk("bypass_iss_valid", 32'(iss_valid), 1);
    tick();
    chk("bypass_count_after", 32'(count), 0);

    // Fill to capacity with issue stalled; pointers wrap during fill.
    iss_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      e = mk(32'h200 + 32'(4*i), OP_ORI, 1'b0, 5'd0, 32'(i), 1'b0, 5'd0, 32'(3*i));
      enq_valid = 1'b1; enq_elem = e;
      push_exp(e, 32'(i), 32'(3*i));
      tick();
    end
    chk("full_count", 32'(count), 8);
    chk("full_enq_ready", 32'(enq_ready), 0);
    e = mk(32'h300, OP_ORI, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    enq_elem = e;
    tick();
    chk("full_refuse_count", 32'(count), 8);
    // Full queue issuing: the concurrent enqueue is still refused.
    iss_ready = 1'b1;
    tick();
    chk("full_issue_no_enq", 32'(count), 7);
    e = mk(32'h304, OP_ORI, 1'b0, 5'd0, 32'h44, 1'b0, 5'd0, 32'h45);
    enq_elem = e;
    push_exp(e, 32'h44, 32'h45);
    tick();
    enq_valid = 1'b0;
    chk("enq_and_issue_count", 32'(count), 7);
    for (int i = 0; i < 7; i++) tick();
    chk("drain_count", 32'(count), 0);
    chk("drain_iss_valid", 32'(iss_valid), 0);

    // Stalled head blocks a ready younger entry; one broadcast wakes both operands.
    e = mk(32'h400, OP_ADDU, 1'b1, 5'd9, 32'h0, 1'b1, 5'd9, 32'h0);
    enq_valid = 1'b1; enq_elem = e;
    push_exp(e, 32'h99, 32'h99);
    tick();
    e = mk(32'h404, OP_ORI, 1'b0, 5'd0, 32'h1, 1'b0, 5'd0, 32'h2);
    enq_elem = e;
    push_exp(e, 32'h1, 32'h2);
    tick();
    enq_valid = 1'b0;
    chk("stall_iss_valid", 32'(iss_valid), 0);
    chk("stall_count", 32'(count), 2);
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h77;
    tick();
    chk("stall_r0_bcast_no_wake", 32'(iss_valid), 0);
    wb_addr = 5'd9; wb_data = 32'h99;
    tick();
    wb_valid = 1'b0;
    chk("stall_woken", 32'(iss_valid), 1);
    chk("stall_woken_count", 32'(count), 2);
    tick();
    chk("stall_second_ready", 32'(iss_valid), 1);
    chk("stall_second_count", 32'(count), 1);
    tick();
    chk("stall_drained", 32'(count), 0);

    // Flush at count=5 with a simultaneous enqueue.
    iss_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = mk(32'h600 + 32'(4*i), OP_OR, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      enq_valid = 1'b1; enq_elem = e;
      tick();
    end
    chk("pre_flush_count", 32'(count), 5);
    flush = 1'b1;
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_iss_valid", 32'(iss_valid), 0);
    iss_ready = 1'b1;
    tick();
    chk("flush_stays_empty", 32'(count), 0);

    // Reset mid-stream, with an enqueue in the reset cycle.
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = mk(32'h700 + 32'(4*i), OP_OR, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      enq_valid = 1'b1; enq_elem = e;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; enq_valid = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_iss_valid", 32'(iss_valid), 0);
    chk("rst_enq_ready", 32'(enq_ready), 1);

    // Queue still works after the reset.
    iss_ready = 1'b1;
    e = mk(32'h800, OP_SUBU, 1'b1, 5'd3, 32'h0, 1'b1, 5'd4, 32'h0);
    enq_valid = 1'b1; enq_elem = e;
    rf_num1_ready = 1'b1; rf_num1_data = 32'h31; rf_num2_ready = 1'b1; rf_num2_data = 32'h42;
    push_exp(e, 32'h31, 32'h42);
    tick();
    enq_valid = 1'b0; rf_num1_ready = 1'b0; rf_num2_ready = 1'b0;
    tick();
    chk("post_rst_count", 32'(count), 0);

    tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
